// File: rtl/adder_nbit_serial_if.sv
// Handshake and data bundle for adder_nbit_serial.
// master: the requester driving operands/start; slave: the serial adder.
interface adder_nbit_serial_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             overflow;

    modport master (
        output start, sub, a, b, carry_in,
        input  busy, done, sum, carry_out, overflow
    );

    modport slave (
        input  start, sub, a, b, carry_in,
        output busy, done, sum, carry_out, overflow
    );
endinterface

// File: rtl/adder_nbit_serial.sv
// Multi-cycle WIDTH-bit adder/subtractor, CHUNK bits per clock with a
// registered inter-chunk carry. Start/busy/done handshake, N+1 cycles per op.
// Optional macro ADDER_SAT_EN: on signed overflow the result is replaced by
// the signed saturation value (0x7F..F or 0x80..0, chosen by the MSB of A).
module adder_nbit_serial #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    adder_nbit_serial_if.slave   bus
);
    localparam int N  = WIDTH / CHUNK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    // Operand chunks and the partial sum with chunk k replaced.
    logic [CHUNK-1:0] a_chunks [N];
    logic [CHUNK-1:0] b_chunks [N];
    logic [WIDTH-1:0] sum_upd;
    logic [CHUNK:0]   chunk_res;
    logic             msb_cin;
    logic             ovf_now;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_chunk
            assign a_chunks[gi] = a_q[gi*CHUNK +: CHUNK];
            assign b_chunks[gi] = b_q[gi*CHUNK +: CHUNK];
            assign sum_upd[gi*CHUNK +: CHUNK] =
                (k_q == KW'(gi)) ? chunk_res[CHUNK-1:0] : sum_q[gi*CHUNK +: CHUNK];
        end
    endgenerate

    // One CHUNK-wide slice of the ripple chain; carry into the MSB is
    // recovered from the MSB sum bit (s = a ^ b ^ cin) so no extra adder is needed.
    always_comb begin
        chunk_res = {1'b0, a_chunks[k_q]} + {1'b0, b_chunks[k_q]} + {{CHUNK{1'b0}}, carry_q};
        msb_cin   = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ chunk_res[CHUNK-1];
        ovf_now   = msb_cin ^ chunk_res[CHUNK];
    end

    // Next-state, operand latch and per-chunk accumulation.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        k_d     = k_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d = S_RUN;
                    a_d     = bus.a;
                    b_d     = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.sub ? 1'b1 : bus.carry_in;
                    k_d     = '0;
                    sum_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                sum_d   = sum_upd;
                carry_d = chunk_res[CHUNK];
                if (k_q == K_LAST) begin
                    state_d = S_DONE;
                    cout_d  = chunk_res[CHUNK];
                    ovf_d   = ovf_now;
`ifdef ADDER_SAT_EN
                    // Clamp toward the sign of A: only A's sign can have pushed past the limit.
                    if (ovf_now) begin
                        sum_d = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                             : {1'b0, {(WIDTH-1){1'b1}}};
                    end
`endif
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            k_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            k_q     <= k_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.busy      = (state_q == S_RUN);
    assign bus.done      = (state_q == S_DONE);
    assign bus.sum       = sum_q;
    assign bus.carry_out = cout_q;
    assign bus.overflow  = ovf_q;
endmodule

// File: doc/adder_nbit_serial.md
Name: adder_nbit_serial

Overview:
- Parametrised multi-cycle successor to the fixed-width ripple adders.
- Adds or subtracts two WIDTH-bit operands CHUNK bits per clock, using a registered carry between chunks.
- Uses a start/busy/done handshake.
- Used where wide add/sub is needed but a single-cycle WIDTH-bit ripple chain would not meet timing.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a positive multiple of CHUNK.
- CHUNK, 4, bits processed per RUN cycle. N = WIDTH/CHUNK RUN cycles per operation.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous active-high reset
- start  input  1  request new operation; sampled only in IDLE or DONE
- sub  input  1  0 = add, 1 = subtract (a - b); sampled with start
- a  input  WIDTH  operand A; sampled with start
- b  input  WIDTH  operand B; sampled with start
- carry_in  input  1  carry into bit 0 for add; ignored when sub=1; sampled with start
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse; result valid
- sum  output  WIDTH  result
- carry_out  output  1  carry out of MSB (for sub: 1 = no borrow)
- overflow  output  1  signed two's-complement overflow

Behaviour:
- Reset: rst=1 at a clock edge forces IDLE and clears busy, done, sum, carry_out, overflow, the operand registers and the chunk counter to 0. Reset has priority over all other inputs, including mid-RUN; the in-flight operation is discarded.
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN when start=1. DONE -> RUN when start=1.
- DONE -> IDLE when start=0. DONE lasts exactly one cycle.
- RUN -> DONE after N RUN cycles. start is ignored in RUN, with no queuing.
- On accept, latch:
  - A = a.
  - B = sub ? ~b : b.
  - carry register = sub ? 1 : carry_in.
  - Clear the chunk counter k to 0 and clear sum to 0.
- RUN cycle k (0..N-1):
  - Compute A[k*CHUNK +: CHUNK] + B[k*CHUNK +: CHUNK] + carry.
  - Write the low CHUNK bits into sum[k*CHUNK +: CHUNK] and register the chunk carry-out.
  - Increment k.
  - On k = N-1, also capture the carry into bit WIDTH-1.
- Result flags:
  - carry_out = final carry.
  - overflow = (carry into MSB) XOR (carry out of MSB).
  - Both registered, and updated only on the final RUN cycle.
- Timing:
  - busy = 1 exactly in RUN (N cycles).
  - done = 1 exactly in DONE.
  - Latency: start sampled at edge t gives done=1 in the cycle after edge t+N (N+1 edges from accept).
- Holding: sum, carry_out and overflow hold their values from DONE until the next operation is accepted. During RUN, sum is partial and not valid.
- Back-to-back: start=1 while done=1 is accepted; busy rises the next cycle. Maximum throughput is one result per N+1 cycles.
- Wrap-around: all arithmetic is modulo 2^WIDTH. The carry leaving chunk N-1 goes only to carry_out and is never wrapped into bit 0.
- Degenerate case: CHUNK = WIDTH gives N = 1, a single RUN cycle.

Optional Feature:
- Macro: ADDER_SAT_EN.
- Defined:
  - When overflow=1 at completion, sum is replaced in the DONE cycle by the signed saturation value.
  - The value is 0x7F..F if the MSB of A is 0, else 0x80..0; overflow is still reported as 1.
  - carry_out is unaffected.
- Not defined: sum is the raw wrapped result; no saturation logic is present.

Test Plan:
- WIDTH=16, CHUNK=4, a=0x1234, b=0x0FED, sub=0, carry_in=0, start pulsed one cycle -> busy high 4 cycles, done in the 5th cycle after accept; sum=0x2221, carry_out=0, overflow=0.
- a=0xFFFF, b=0x0001, sub=0, carry_in=0 -> sum=0x0000, carry_out=1, overflow=0. Repeat with carry_in=1 and b=0x0000 -> same result.
- a=0x7FFF, b=0x0001, sub=0 -> overflow=1; sum=0x8000 without ADDER_SAT_EN, 0x7FFF with it.
- Subtraction:
  - a=0x0005, b=0x0007, sub=1, carry_in=1 -> sum=0xFFFE, carry_out=0, overflow=0.
  - a=0x8000, b=0x0001, sub=1 -> overflow=1; sum=0x7FFF without ADDER_SAT_EN, 0x8000 with it.
- Handshake:
  - start re-asserted with new operands during RUN -> ignored; result matches the first operands.
  - start held high through DONE -> second operation accepted; a second done pulse occurs exactly 5 cycles after the first.
- Reset: rst pulsed in the 2nd RUN cycle -> next cycle busy=0, done=0, sum=0, carry_out=0, overflow=0, state IDLE. A subsequent start completes normally with the correct result.
